// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// queue entry layout and fetch defaults.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'b0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          BUF_DEPTH        = 2;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_BUSY = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    typedef struct packed {
        logic [31:0] pc_4;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buf.sv
// Two-entry FIFO holding {PC+4, instruction} pairs between instruction
// memory and the IF/ID register; flush wins over push and pop.
module fetch_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [63:0] push_data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [1:0]  cnt_o,
    output logic [63:0] head_o
);

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0][63:0] entries;

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        logic [63:0] entry_q;

        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q <= '0;
            end else if (push_i && !flush_i && (wr_ptr_q == 1'(gi))) begin
                entry_q <= push_data_i;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = entries[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, runs one outstanding req/ack transfer at a
// time and feeds a 2-entry instruction queue ahead of IF/ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Hold,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        IF_Valid,
    output logic [31:0] IF_PC_4,
    output logic [31:0] IF_Instruct
);

    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    logic         push, pop, flush;
    logic [1:0]   cnt;
    logic [2:0]   cnt_after_push;
    logic [31:0]  pc_plus4;
    logic [31:0]  redir_pc;
    logic [63:0]  head_raw;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign IF_Valid       = (cnt != 2'd0);
    assign pop            = IF_Valid & ~Hold & ~Redirect;
    assign flush          = Redirect;
    assign pc_plus4       = pc_q + 32'd4;
    assign redir_pc       = align_word(Redirect_PC);
    assign cnt_after_push = {1'b0, cnt} + 3'd1 - {2'b00, pop};
    assign push_entry     = '{pc_4: pc_plus4, instr: IMem_Data};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (Redirect) begin
                    pc_d = redir_pc;
                end else if (cnt < 2'd2) begin
                    state_d = FETCH_BUSY;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            FETCH_BUSY: begin
                if (IMem_Ack && !Redirect) begin
                    push = 1'b1;
                    pc_d = pc_plus4;
                    // Keep streaming only while the queue still has room after this push.
                    if (cnt_after_push < 3'd2) begin
                        addr_d = pc_plus4;
                    end else begin
                        state_d = FETCH_IDLE;
                        req_d   = 1'b0;
                    end
                end else if (IMem_Ack && Redirect) begin
                    pc_d    = redir_pc;
                    req_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end else if (Redirect) begin
                    pc_d    = redir_pc;
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (IMem_Ack) begin
                    req_d   = 1'b0;
                    state_d = FETCH_IDLE;
                end
                if (Redirect) begin
                    pc_d = redir_pc;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .cnt_o       (cnt),
        .head_o      (head_raw)
    );

    // IF_* come only from queue registers, never from the memory inputs.
    assign head        = fetch_entry_t'(head_raw);
    assign IMem_Req    = req_q;
    assign IMem_Addr   = addr_q;
    assign IF_PC_4     = IF_Valid ? head.pc_4  : 32'h0;
    assign IF_Instruct = IF_Valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a latency-configurable memory model
// answers requests, and every consumed IF_* entry is checked against a queue.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Hold = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_PC = 32'h0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Data = 32'h0;
    logic        IF_Valid;
    logic [31:0] IF_PC_4;
    logic [31:0] IF_Instruct;

    int total = 0;
    int bad = 0;
    int npop = 0;
    int mem_lat = 0;
    int wait_cnt = 0;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;
    exp_t exp_q[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .Hold        (Hold),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .IMem_Req    (IMem_Req),
        .IMem_Addr   (IMem_Addr),
        .IMem_Ack    (IMem_Ack),
        .IMem_Data   (IMem_Data),
        .IF_Valid    (IF_Valid),
        .IF_PC_4     (IF_PC_4),
        .IF_Instruct (IF_Instruct)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    task automatic mem_step();
        if (!reset || !IMem_Req) begin
            IMem_Ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= mem_lat) begin
            IMem_Ack  = 1'b1;
            IMem_Data = memf(IMem_Addr);
            wait_cnt  = 0;
        end else begin
            IMem_Ack  = 1'b0;
            IMem_Data = 32'hBAD0_0000;
            wait_cnt++;
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (reset) begin
            if (IF_Valid === 1'b1 && !Hold && !Redirect) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got pc4=%h ins=%h want=none", IF_PC_4, IF_Instruct);
                end else begin
                    e = exp_q.pop_front();
                    npop++;
                    $display("pop pc4=%h ins=%h", IF_PC_4, IF_Instruct);
                    if (IF_PC_4 !== e.pc4 || IF_Instruct !== e.ins) begin
                        bad++;
                        $display("FAIL pop_data got pc4=%h ins=%h want pc4=%h ins=%h",
                                 IF_PC_4, IF_Instruct, e.pc4, e.ins);
                    end
                end
            end else if (IF_Valid !== 1'b1) begin
                total++;
                if (IF_PC_4 !== 32'h0 || IF_Instruct !== 32'h0) begin
                    bad++;
                    $display("FAIL empty_outputs got pc4=%h ins=%h want 0/0", IF_PC_4, IF_Instruct);
                end
            end
        end
    endtask

    task automatic push_range(input logic [31:0] base, input int n);
        exp_t e;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            e.pc4 = a + 32'd4;
            e.ins = memf(a);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int i = 0; i < budget && npop < target; i++) @(negedge clk);
        total++;
        if (npop < target) begin
            bad++;
            $display("FAIL pop_timeout got=%0d want=%0d", npop, target);
        end
    endtask

    task automatic apply_reset(input int lat);
        @(posedge clk); #1;
        reset = 1'b0;
        Hold = 1'b0;
        Redirect = 1'b0;
        mem_lat = lat;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        npop = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", IMem_Req); end
        total++; if (IMem_Addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", IMem_Addr); end
        total++; if (IF_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", IF_Valid); end
        total++; if (IF_PC_4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h want=0", IF_PC_4); end
        total++; if (IF_Instruct !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", IF_Instruct); end
    endtask

    task automatic test_stream();
        apply_reset(0);
        push_range(32'h0, 40);
        @(negedge clk);
        total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL stream_idle_req got=%b want=0", IMem_Req); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (IMem_Req !== 1'b1 || IMem_Addr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL stream_addr got req=%b addr=%h want req=1 addr=%h", IMem_Req, IMem_Addr, 32'(4 * k));
            end
            if (k < 2) begin
                total++;
                if (IF_Valid !== (k == 1)) begin
                    bad++;
                    $display("FAIL stream_valid_latency got=%b want=%b", IF_Valid, (k == 1));
                end
            end
        end
        wait_pops(30, 60);
    endtask

    task automatic test_hold();
        logic [31:0] head_pc4;
        apply_reset(0);
        push_range(32'h0, 40);
        repeat (6) @(posedge clk);
        #1;
        Hold = 1'b1;
        head_pc4 = exp_q[0].pc4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (IF_Valid !== 1'b1 || IF_PC_4 !== head_pc4) begin
                bad++;
                $display("FAIL hold_head got valid=%b pc4=%h want valid=1 pc4=%h", IF_Valid, IF_PC_4, head_pc4);
            end
            if (k >= 2) begin
                total++;
                if (IMem_Req !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_req_drop got=%b want=0", IMem_Req);
                end
            end
        end
        @(posedge clk); #1;
        Hold = 1'b0;
        wait_pops(25, 60);
    endtask

    task automatic test_redirect_busy();
        apply_reset(3);
        @(posedge clk); #1;
        Redirect = 1'b1;
        Redirect_PC = 32'h0000_0100;
        exp_q.delete();
        push_range(32'h0000_0100, 8);
        npop = 0;
        @(posedge clk); #1;
        Redirect = 1'b0;
        @(negedge clk);
        total++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0 || IF_Valid !== 1'b0 || IF_Instruct !== 32'h0) begin
            bad++;
            $display("FAIL drop_state got req=%b addr=%h valid=%b ins=%h want 1/0/0/0",
                     IMem_Req, IMem_Addr, IF_Valid, IF_Instruct);
        end
        for (int i = 0; i < 10 && IMem_Req === 1'b1; i++) @(negedge clk);
        total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL drop_req_release got=%b want=0", IMem_Req); end
        for (int i = 0; i < 10 && IMem_Req !== 1'b1; i++) @(negedge clk);
        total++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0000_0100) begin
            bad++;
            $display("FAIL drop_next_addr got req=%b addr=%h want req=1 addr=00000100", IMem_Req, IMem_Addr);
        end
        wait_pops(6, 100);
    endtask

    task automatic test_redirect_ack();
        apply_reset(0);
        push_range(32'h0, 40);
        repeat (8) @(posedge clk);
        #1;
        Redirect = 1'b1;
        Redirect_PC = 32'h0000_0203;
        exp_q.delete();
        push_range(32'h0000_0200, 20);
        npop = 0;
        @(posedge clk); #1;
        Redirect = 1'b0;
        @(negedge clk);
        total++;
        if (IF_Valid !== 1'b0 || IMem_Req !== 1'b0) begin
            bad++;
            $display("FAIL ackredir_flush got valid=%b req=%b want 0/0", IF_Valid, IMem_Req);
        end
        @(negedge clk);
        total++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0000_0200) begin
            bad++;
            $display("FAIL ackredir_addr got req=%b addr=%h want req=1 addr=00000200", IMem_Req, IMem_Addr);
        end
        wait_pops(10, 60);
    endtask

    task automatic test_wrap();
        apply_reset(0);
        Redirect = 1'b1;
        Redirect_PC = 32'hFFFF_FFF8;
        push_range(32'hFFFF_FFF8, 20);
        @(posedge clk); #1;
        Redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL wrap_addr got req=%b addr=%h want req=1 addr=fffffff8", IMem_Req, IMem_Addr);
        end
        wait_pops(10, 60);
    endtask

    task automatic test_reset_mid_busy();
        apply_reset(0);
        push_range(32'h0, 40);
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (IMem_Req !== 1'b0 || IF_Valid !== 1'b0 || IF_PC_4 !== 32'h0 || IMem_Addr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got req=%b valid=%b pc4=%h addr=%h want 0/0/0/0",
                     IMem_Req, IF_Valid, IF_PC_4, IMem_Addr);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        npop = 0;
        push_range(32'h0, 20);
        @(negedge clk);
        total++; if (IMem_Req !== 1'b0) begin bad++; $display("FAIL rel_idle_req got=%b want=0", IMem_Req); end
        @(negedge clk);
        total++;
        if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin
            bad++;
            $display("FAIL rel_first_addr got req=%b addr=%h want req=1 addr=00000000", IMem_Req, IMem_Addr);
        end
        wait_pops(5, 40);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mem_step();
                mon_step();
            end
        join_none
        test_reset();
        test_stream();
        test_hold();
        test_redirect_busy();
        test_redirect_ack();
        test_wrap();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
